halton_pair_buffer: RTL and testbench
=====================================

# halton_pair_buffer

Downstream stage of the 2-D Halton generator: it throttles the generator's `pop_enable`/`valid` pulse interface and buffers the resulting (x, y) point pairs in a small FIFO. It presents them to the consumer (sampler / integrator datapath) as a ready/valid stream. Issue is credit-based, so no generated point is ever lost or overwritten. Reseed requests are forwarded to the generator, and stale in-flight points are discarded.

## Interface
- `DEPTH`, 4: FIFO entries; power of two, ≥4. ≥4 sustains 1 point/cycle.
- `WIDTH`, 32: width of each coordinate.
- `clk` in 1: single clock; everything samples on rising edge.
- `rst` in 1: synchronous, active-high reset.
- `enable` in 1: when low, no new pops are issued; buffered data still drains.
- `reseed_req` in 1: one-cycle request to reseed the generator and flush the buffer.
- `seed_in` in 32: seed captured with `reseed_req`.
- `gen_pop_enable` out 1: registered pop request to the generator.
- `gen_reseed_enable` out 1: registered reseed strobe to the generator.
- `gen_seed` out 32: registered seed to the generator.
- `gen_valid` in 1: generator output valid (one cycle after it samples a pop).
- `gen_out_0`, `gen_out_1` in WIDTH: generator coordinates.
- `m_valid` out 1: head of FIFO valid.
- `m_ready` in 1: consumer accepts the head when `m_valid && m_ready`.
- `m_x`, `m_y` out WIDTH: head pair (first-word-fall-through).
- `level` out $clog2(DEPTH)+1: FIFO occupancy.
- `overflow` out 1: sticky error flag, cleared only by `rst`.

## Operation
- **State**
  - FIFO: write pointer, read pointer, occupancy.
  - `outstanding` (0..DEPTH): pops issued but not yet returned.
  - `discard` (0..DEPTH): returns that must be dropped.
- **Credit**
  - Next-cycle `gen_pop_enable` = `enable && !reseed_req && (level + outstanding < DEPTH)`.
  - Credit uses registered values only. A consumer pop in the same cycle frees credit on the following cycle.
- **outstanding update**
  - +1 on each edge where `gen_pop_enable` is registered high.
  - −1 on each edge where `gen_valid` is sampled high while `discard == 0`.
  - Net 0 when both happen.
- **Write**
  - `gen_valid && discard == 0` writes {`gen_out_0`, `gen_out_1`}.
  - `gen_valid && discard > 0` drops the data and decrements `discard`.
- **Read**
  - `m_valid && m_ready` advances the read pointer.
  - Simultaneous read and write on a non-empty FIFO leaves `level` unchanged.
  - Simultaneous read and write on an empty FIFO is not possible: the write is visible a cycle later.
- **Overflow**
  - Write attempted with `level == DEPTH` and no same-cycle read: data dropped, `overflow` set.
  - `gen_valid` with `outstanding == 0 && discard == 0`: also sets `overflow`, and the data is dropped.
- **Reseed** (edge where `reseed_req` is sampled)
  - FIFO emptied: pointers and `level` = 0.
  - `discard` <= `outstanding` − (1 if `gen_valid` was accepted this edge).
  - `outstanding` <= 0.
  - Next cycle: `gen_reseed_enable` = 1, `gen_seed` = `seed_in`, `gen_pop_enable` = 0.
  - The following cycle: `gen_reseed_enable` = 0 and normal credit issue resumes.
  - Back-to-back `reseed_req` is allowed; the last one wins.
- Pointers wrap modulo DEPTH.
- `gen_seed` holds its value until the next reseed.

## Timing
- **Reset values**: `gen_pop_enable` = 0, `gen_reseed_enable` = 0, `gen_seed` = 0, `m_valid` = 0, `m_x` = 0, `m_y` = 0, `level` = 0, `overflow` = 0; `outstanding` = 0, `discard` = 0.
- **Pop-to-output latency**:
  - Edge t registers `gen_pop_enable`.
  - Generator samples it at t+1 and asserts `gen_valid`.
  - Buffer writes at t+2.
  - `m_valid`/`m_x`/`m_y` are visible after t+2, i.e. 2 cycles from `gen_pop_enable` high.
  - First `m_valid` after reset release with `enable` = 1 occurs 3 cycles after the first enabled edge.
- **Steady state** with `m_ready` held high: `outstanding` = 2, `level` ≤ 1, one pair per cycle.
- **Backpressure**: with `m_ready` low, issue stops once `level + outstanding == DEPTH`. The FIFO fills exactly to DEPTH with no overflow.
- Reset asserted mid-operation overrides everything, including a pending reseed.

## Test plan
- **Reset/start**: `rst` 2 cycles, `enable` = 1, `m_ready` = 1, generator model (base 2/3) from count 0 → `m_x` sequence 1024, 512, 1536, 256; `m_y` sequence 729, 1458, 243, 972; first `m_valid` on cycle 3 after reset, then 1/cycle.
- **Full backpressure**: `m_ready` = 0 for 20 cycles, DEPTH = 4 → `level` = 4, `gen_pop_enable` = 0 thereafter, `overflow` = 0. Release `m_ready` → 4 pairs in order with no gap, then streaming resumes.
- **Reseed mid-stream**: `reseed_req` with `seed_in` = 2 while `outstanding` = 2 → `gen_reseed_enable`/`gen_seed` = 2 for one cycle, 2 stale returns dropped, next `m_x`/`m_y` = 256/972.
- **Enable gating**: drop `enable` with `level` = 1 → the in-flight pairs still arrive and drain, no new pops, `m_valid` falls once empty.
- **Error injection**: force `gen_valid` with no outstanding pop → data dropped, `overflow` = 1 and stays 1 until `rst`.
- **Random `m_ready`** (50%) for 1000 points → order preserved, no drops, `overflow` = 0, `level` never > DEPTH.

Source files
------------

// File: rtl/halton_pair_buffer.sv
// rtl/halton_pair_buffer.sv - credit-throttled FIFO between the Halton point generator and its consumer
// Pops are only issued while buffered plus in-flight points fit, so no return is ever overwritten.
module halton_pair_buffer #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     enable,
  input  logic                     reseed_req,
  input  logic [31:0]              seed_in,
  output logic                     gen_pop_enable,
  output logic                     gen_reseed_enable,
  output logic [31:0]              gen_seed,
  input  logic                     gen_valid,
  input  logic [WIDTH-1:0]         gen_out_0,
  input  logic [WIDTH-1:0]         gen_out_1,
  output logic                     m_valid,
  input  logic                     m_ready,
  output logic [WIDTH-1:0]         m_x,
  output logic [WIDTH-1:0]         m_y,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [AW-1:0] PTR_ONE = 1;

  logic [WIDTH-1:0] mem_x [DEPTH];
  logic [WIDTH-1:0] mem_y [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    outstanding;
  logic [CW-1:0]    discard;

  logic          rd_fire;
  logic          full;
  logic          drop_stale;
  logic          stray;
  logic          ret_ok;
  logic          wr_fire;
  logic          overflow_set;
  logic          pop_next;
  logic [CW:0]   credit_sum;

  assign rd_fire    = m_valid && m_ready;
  assign full       = (level == CW'(DEPTH));
  assign drop_stale = gen_valid && (discard != '0);
  // A return nobody asked for is an upstream protocol error, never buffered.
  assign stray      = gen_valid && (discard == '0) && (outstanding == '0);
  assign ret_ok     = gen_valid && (discard == '0) && (outstanding != '0);
  assign wr_fire    = ret_ok && (!full || rd_fire);

  assign overflow_set = stray || (ret_ok && full && !rd_fire && !reseed_req);

  // outstanding already counts the pop registered this cycle, so the sum is the
  // worst-case occupancy once everything in flight has landed.
  assign credit_sum = {1'b0, level} + {1'b0, outstanding};
  assign pop_next   = enable && !reseed_req && (credit_sum < (CW+1)'(DEPTH));

  always_ff @(posedge clk) begin
    if (rst) begin
      gen_pop_enable    <= 1'b0;
      gen_reseed_enable <= 1'b0;
      gen_seed          <= '0;
      wr_ptr            <= '0;
      rd_ptr            <= '0;
      level             <= '0;
      outstanding       <= '0;
      discard           <= '0;
      overflow          <= 1'b0;
    end else begin
      gen_pop_enable    <= pop_next;
      gen_reseed_enable <= reseed_req;
      if (reseed_req) begin
        gen_seed <= seed_in;
      end
      if (overflow_set) begin
        overflow <= 1'b1;
      end
      if (reseed_req) begin
        wr_ptr      <= '0;
        rd_ptr      <= '0;
        level       <= '0;
        outstanding <= '0;
        // Earlier pending discards are kept so back-to-back reseeds stay exact.
        discard     <= discard - CW'(drop_stale) + outstanding - CW'(ret_ok);
      end else begin
        if (wr_fire) begin
          wr_ptr <= wr_ptr + PTR_ONE;
        end
        if (rd_fire) begin
          rd_ptr <= rd_ptr + PTR_ONE;
        end
        level       <= level + CW'(wr_fire) - CW'(rd_fire);
        outstanding <= outstanding + CW'(pop_next) - CW'(ret_ok);
        discard     <= discard - CW'(drop_stale);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && !reseed_req && wr_fire) begin
      mem_x[wr_ptr] <= gen_out_0;
      mem_y[wr_ptr] <= gen_out_1;
    end
  end

  assign m_valid = (level != '0);
  assign m_x     = m_valid ? mem_x[rd_ptr] : '0;
  assign m_y     = m_valid ? mem_y[rd_ptr] : '0;

endmodule

// File: tb/tb_halton_pair_buffer.sv
// tb/tb_halton_pair_buffer.sv - directed bench for halton_pair_buffer with a base-2/3 generator model
module tb_halton_pair_buffer;

  localparam int DEPTH = 4;
  localparam int WIDTH = 32;

  logic              clk = 1'b0;
  logic              rst;
  logic              enable;
  logic              reseed_req;
  logic [31:0]       seed_in;
  logic              gen_pop_enable;
  logic              gen_reseed_enable;
  logic [31:0]       gen_seed;
  logic              gen_valid;
  logic [WIDTH-1:0]  gen_out_0;
  logic [WIDTH-1:0]  gen_out_1;
  logic              m_valid;
  logic              m_ready;
  logic [WIDTH-1:0]  m_x;
  logic [WIDTH-1:0]  m_y;
  logic [2:0]        level;
  logic              overflow;

  logic              model_valid;
  logic [31:0]       model_count;
  logic              inj;

  int checks = 0;
  int errors = 0;
  int exp_idx;
  int received;

  always #5 clk = ~clk;

  halton_pair_buffer #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
    .clk(clk), .rst(rst), .enable(enable), .reseed_req(reseed_req), .seed_in(seed_in),
    .gen_pop_enable(gen_pop_enable), .gen_reseed_enable(gen_reseed_enable), .gen_seed(gen_seed),
    .gen_valid(gen_valid), .gen_out_0(gen_out_0), .gen_out_1(gen_out_1),
    .m_valid(m_valid), .m_ready(m_ready), .m_x(m_x), .m_y(m_y),
    .level(level), .overflow(overflow)
  );

  function automatic logic [31:0] rad2(input int unsigned i);
    int unsigned r = 0;
    int unsigned s = 2048;
    while (i > 0) begin
      s = s / 2;
      r = r + (i % 2) * s;
      i = i / 2;
    end
    return r;
  endfunction

  function automatic logic [31:0] rad3(input int unsigned i);
    int unsigned r = 0;
    int unsigned s = 2187;
    while (i > 0) begin
      s = s / 3;
      r = r + (i % 3) * s;
      i = i / 3;
    end
    return r;
  endfunction

  // Generator: answers a sampled pop one cycle later; a reseed makes the next point index seed+2.
  always_ff @(posedge clk) begin
    if (rst) begin
      model_valid <= 1'b0;
      model_count <= '0;
      gen_out_0   <= '0;
      gen_out_1   <= '0;
    end else begin
      model_valid <= gen_pop_enable;
      if (gen_reseed_enable) begin
        model_count <= gen_seed + 32'd1;
      end else if (gen_pop_enable) begin
        model_count <= model_count + 32'd1;
        gen_out_0   <= rad2(model_count + 32'd1);
        gen_out_1   <= rad3(model_count + 32'd1);
      end
    end
  end

  assign gen_valid = model_valid | inj;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Called at a falling edge with inputs set for the coming rising edge.
  task automatic cycle();
    if (m_valid && m_ready) begin
      chk("stream_x", m_x, rad2(exp_idx));
      chk("stream_y", m_y, rad3(exp_idx));
      exp_idx++;
      received++;
    end
    chk("level_bound", level <= 3'd4, 1);
    @(negedge clk);
  endtask

  initial begin
    int w;
    int cyc;
    rst = 1'b1; enable = 1'b0; reseed_req = 1'b0; m_ready = 1'b0; inj = 1'b0; seed_in = '0;
    exp_idx = 1; received = 0;
    @(negedge clk);
    @(negedge clk);
    chk("rst_pop", gen_pop_enable, 0);
    chk("rst_reseed", gen_reseed_enable, 0);
    chk("rst_seed", gen_seed, 0);
    chk("rst_valid", m_valid, 0);
    chk("rst_mx", m_x, 0);
    chk("rst_my", m_y, 0);
    chk("rst_level", level, 0);
    chk("rst_overflow", overflow, 0);

    rst = 1'b0; enable = 1'b1; m_ready = 1'b1;
    cycle();
    chk("start_pop", gen_pop_enable, 1);
    chk("start_valid_c1", m_valid, 0);
    cycle();
    chk("start_valid_c2", m_valid, 0);
    cycle();
    chk("start_valid_c3", m_valid, 1);
    chk("start_x1", m_x, 1024);
    chk("start_y1", m_y, 729);
    cycle();
    chk("start_x2", m_x, 512);
    chk("start_y2", m_y, 1458);
    cycle();
    chk("start_x3", m_x, 1536);
    chk("start_y3", m_y, 243);
    cycle();
    chk("start_x4", m_x, 256);
    chk("start_y4", m_y, 972);
    chk("steady_level", level, 1);
    chk("steady_pop", gen_pop_enable, 1);
    repeat (6) cycle();

    m_ready = 1'b0;
    repeat (20) cycle();
    chk("bp_level", level, 4);
    chk("bp_pop", gen_pop_enable, 0);
    chk("bp_overflow", overflow, 0);
    m_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      chk("bp_drain_valid", m_valid, 1);
      cycle();
    end

    reseed_req = 1'b1; seed_in = 32'd2;
    cycle();
    reseed_req = 1'b0;
    exp_idx = 4;
    chk("rs_strobe", gen_reseed_enable, 1);
    chk("rs_seed", gen_seed, 2);
    chk("rs_pop", gen_pop_enable, 0);
    chk("rs_level", level, 0);
    cycle();
    chk("rs_strobe_off", gen_reseed_enable, 0);
    chk("rs_seed_hold", gen_seed, 2);
    chk("rs_pop_resume", gen_pop_enable, 1);
    chk("rs_stale1", m_valid, 0);
    cycle();
    chk("rs_stale2", m_valid, 0);
    w = 0;
    while (!m_valid && w < 8) begin
      cycle();
      w++;
    end
    chk("rs_first_valid", m_valid, 1);
    chk("rs_x", m_x, 256);
    chk("rs_y", m_y, 972);
    repeat (6) cycle();

    chk("en_level_before", level, 1);
    enable = 1'b0;
    cycle();
    chk("en_pop_off", gen_pop_enable, 0);
    repeat (5) cycle();
    chk("en_drained_valid", m_valid, 0);
    chk("en_drained_level", level, 0);
    chk("en_pop_still_off", gen_pop_enable, 0);

    inj = 1'b1;
    cycle();
    inj = 1'b0;
    chk("inj_overflow", overflow, 1);
    chk("inj_level", level, 0);
    chk("inj_valid", m_valid, 0);
    enable = 1'b1;
    repeat (10) cycle();
    chk("inj_sticky", overflow, 1);
    chk("inj_stream_ok", m_valid, 1);

    rst = 1'b1; reseed_req = 1'b1; seed_in = 32'd7;
    cycle();
    reseed_req = 1'b0;
    cycle();
    chk("rst2_overflow", overflow, 0);
    chk("rst2_level", level, 0);
    chk("rst2_reseed", gen_reseed_enable, 0);
    chk("rst2_seed", gen_seed, 0);
    chk("rst2_pop", gen_pop_enable, 0);

    rst = 1'b0;
    exp_idx = 1; received = 0; cyc = 0;
    while (received < 1000 && cyc < 8000) begin
      m_ready = 1'($urandom_range(0, 1));
      cycle();
      cyc++;
    end
    chk("rand_count", received, 1000);
    chk("rand_overflow", overflow, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
